// File: rtl/fpu_pkg.sv
// Shared definitions for the binary32 round-and-pack datapath.
//   - rounding-mode encodings as presented on rm_i
//   - bit positions inside the {NV,DZ,OF,UF,NX} flag vector
//   - canonical result constants and the exponent bias
//   - operand class carried from normalize to round/pack
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_NV = 4;

  localparam logic [31:0] QNAN_CANON = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG    = 31'h7F80_0000;
  localparam logic [30:0] MAXF_MAG   = 31'h7F7F_FFFF;
  localparam int          EXP_BIAS   = 127;

  typedef enum logic [1:0] {
    CLS_FINITE,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fp_cls_e;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter.
//   in_i  : vector to scan, MSB first
//   cnt_o : number of zeros above the first set bit; W when in_i is all zeros
module fpu_lzc #(
  parameter int unsigned W  = 27,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);

  logic found;

  always_comb begin
    cnt_o = CW'(W);
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && in_i[W-1-i]) begin
        cnt_o = CW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_encoder.sv
// Round-and-pack unit for IEEE-754 binary32. Two-stage elastic pipeline:
// stage 1 normalizes {exp, sig, sticky} so the hidden bit sits at the top
// of m; stage 2 rounds, detects overflow and packs the result into the
// output register.
// Ports:
//   clk_i, reset_i (async, active-low)
//   valid_i/ready_o             : operand handshake
//   sign_i, exp_i, sig_i, sticky_i, is_nan_i, is_inf_i, nv_i, dz_i, rm_i
//   valid_o/ready_i             : result handshake
//   result_o (binary32), flags_o {NV,DZ,OF,UF,NX}
// Build option: FPU_ENC_SUBNORMAL_EN produces gradual underflow; without it
// tiny results flush to signed zero and the denormalizing shifter is absent.
module fpu_encoder
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 10,
  parameter int unsigned SIG_W = 27
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [SIG_W-1:0] sig_i,
  input  logic             sticky_i,
  input  logic             is_nan_i,
  input  logic             is_inf_i,
  input  logic             nv_i,
  input  logic             dz_i,
  input  logic [2:0]       rm_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      result_o,
  output logic [4:0]       flags_o
);

  localparam int unsigned EW = EXP_W + 2;  // headroom for +1 and -(SIG_W-1)
  localparam int unsigned MW = SIG_W - 1;  // normalized significand width
  localparam int unsigned CW = $clog2(SIG_W + 1);

  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_MAX = EW'(2 * EXP_BIAS + 1);

  // Handshake
  logic s1_valid_q, s2_valid_q, s2_adv;

  assign s2_adv  = !s2_valid_q | ready_i;
  assign ready_o = !s1_valid_q | s2_adv;

  // Stage 1: normalize
  logic [CW-1:0]          lz, sh;
  logic signed [EW-1:0]   exp_ext, sh_s, e_n, e_d;
  logic [MW-1:0]          m_n, m_d;
  logic                   st_n, st_d, tiny_d;
  fp_cls_e                cls_d;

  fpu_lzc #(.W(SIG_W), .CW(CW)) u_lzc (
    .in_i  (sig_i),
    .cnt_o (lz)
  );

  assign exp_ext = {{2{exp_i[EXP_W-1]}}, exp_i};
  assign sh      = lz - CW'(1);
  assign sh_s    = $signed({{(EW-CW){1'b0}}, sh});

`ifdef FPU_ENC_SUBNORMAL_EN
  localparam logic signed [EW-1:0] E_SAT = EW'(SIG_W);
  logic signed [EW-1:0] amt;
  logic [CW-1:0]        shamt;
  logic [MW-1:0]        lost;
`endif

  always_comb begin
    if (is_nan_i)                    cls_d = CLS_NAN;
    else if (is_inf_i)               cls_d = CLS_INF;
    else if (sig_i == '0 && !sticky_i) cls_d = CLS_ZERO;
    else                             cls_d = CLS_FINITE;

    if (sig_i[SIG_W-1]) begin
      m_n  = sig_i[SIG_W-1:1];
      st_n = sticky_i | sig_i[0];
      e_n  = exp_ext + E_ONE;
    end else begin
      m_n  = sig_i[SIG_W-2:0] << sh;
      st_n = sticky_i;
      e_n  = exp_ext - sh_s;
    end

    tiny_d = (e_n < E_ONE);
    m_d    = m_n;
    st_d   = st_n;
    e_d    = e_n;

`ifdef FPU_ENC_SUBNORMAL_EN
    amt   = E_ONE - e_n;
    shamt = (amt > E_SAT) ? CW'(SIG_W) : amt[CW-1:0];
    lost  = ~({MW{1'b1}} << shamt);
    if (tiny_d) begin
      m_d  = m_n >> shamt;
      st_d = st_n | (|(m_n & lost));
      e_d  = '0;
    end
`endif
  end

  // Stage 1 registers
  logic                 s1_sign_q, s1_st_q, s1_tiny_q, s1_nv_q, s1_dz_q;
  logic signed [EW-1:0] s1_e_q;
  logic [MW-1:0]        s1_m_q;
  logic [2:0]           s1_rm_q;
  fp_cls_e              s1_cls_q;

  // Stage 2: round and pack
  logic        hidden, g, lsb, rs, inc, nx, of, max_fin;
  logic [22:0] frac;
  logic [7:0]  exp_fld;
  logic [30:0] mag, ovf_mag;
  logic [31:0] res_d;
  logic [4:0]  flg_d;

  assign hidden = s1_m_q[MW-1];
  assign frac   = s1_m_q[MW-2 -: 23];
  assign lsb    = s1_m_q[MW-24];
  assign g      = s1_m_q[MW-25];
  assign rs     = (|s1_m_q[MW-26:0]) | s1_st_q;
  assign nx     = g | rs;

  // A cleared hidden bit means a subnormal (or empty) significand, so the
  // exponent field is zero; a rounding carry then lands in it naturally.
  assign exp_fld = hidden ? s1_e_q[7:0] : 8'h00;
  assign mag     = {exp_fld, frac} + 31'(inc);
  assign of      = (s1_e_q >= E_MAX) | (mag[30:23] == 8'hFF);

  assign max_fin = (s1_rm_q == RM_RTZ)
                 | ((s1_rm_q == RM_RDN) & !s1_sign_q)
                 | ((s1_rm_q == RM_RUP) &  s1_sign_q);
  assign ovf_mag = max_fin ? MAXF_MAG : INF_MAG;

  always_comb begin
    case (s1_rm_q)
      RM_RNE:  inc = g & (rs | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = nx & s1_sign_q;
      RM_RUP:  inc = nx & !s1_sign_q;
      RM_RMM:  inc = g;
      default: inc = g & (rs | lsb);
    endcase
  end

  always_comb begin
    res_d          = {s1_sign_q, mag};
    flg_d          = '0;
    flg_d[FLAG_NV] = s1_nv_q;
    flg_d[FLAG_DZ] = s1_dz_q;
    unique case (s1_cls_q)
      CLS_NAN:  res_d = QNAN_CANON;
      CLS_INF:  res_d = {s1_sign_q, INF_MAG};
      CLS_ZERO: res_d = {s1_sign_q, 31'b0};
      CLS_FINITE: begin
        flg_d[FLAG_NX] = nx;
        if (of) begin
          res_d          = {s1_sign_q, ovf_mag};
          flg_d[FLAG_OF] = 1'b1;
          flg_d[FLAG_NX] = 1'b1;
        end
`ifdef FPU_ENC_SUBNORMAL_EN
        flg_d[FLAG_UF] = s1_tiny_q & nx;
`else
        if (s1_tiny_q) begin
          res_d          = {s1_sign_q, 31'b0};
          flg_d[FLAG_UF] = 1'b1;
          flg_d[FLAG_NX] = 1'b1;
        end
`endif
      end
    endcase
  end

  // Pipeline registers
  logic [31:0] result_q;
  logic [4:0]  flags_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= CLS_ZERO;
      s1_e_q     <= '0;
      s1_m_q     <= '0;
      s1_st_q    <= 1'b0;
      s1_tiny_q  <= 1'b0;
      s1_rm_q    <= '0;
      s1_nv_q    <= 1'b0;
      s1_dz_q    <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      if (ready_o) s1_valid_q <= valid_i;
      if (valid_i && ready_o) begin
        s1_sign_q <= sign_i;
        s1_cls_q  <= cls_d;
        s1_e_q    <= e_d;
        s1_m_q    <= m_d;
        s1_st_q   <= st_d;
        s1_tiny_q <= tiny_d;
        s1_rm_q   <= rm_i;
        s1_nv_q   <= nv_i;
        s1_dz_q   <= dz_i;
      end
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s1_valid_q && s2_adv) begin
        result_q <= res_d;
        flags_q  <= flg_d;
      end
    end
  end

  assign valid_o  = s2_valid_q;
  assign result_o = result_q;
  assign flags_o  = flags_q;

endmodule

// File: tb/tb_fpu_encoder.sv
// Scoreboard bench for fpu_encoder: expected {result, flags} are queued when
// an operand is accepted and compared when the result appears on the output.
module tb_fpu_encoder;
  import fpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i, valid_i, ready_o, sign_i, sticky_i, is_nan_i, is_inf_i;
  logic        nv_i, dz_i, valid_o, ready_i;
  logic [9:0]  exp_i;
  logic [26:0] sig_i;
  logic [2:0]  rm_i;
  logic [31:0] result_o;
  logic [4:0]  flags_o;

  localparam logic [4:0] NX = 5'b00001, UF = 5'b00010, OF = 5'b00100;
  localparam logic [4:0] DZ = 5'b01000, NV = 5'b10000;

  always #5 clk_i = ~clk_i;

  fpu_encoder #(.EXP_W(10), .SIG_W(27)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .sign_i(sign_i), .exp_i(exp_i), .sig_i(sig_i), .sticky_i(sticky_i),
    .is_nan_i(is_nan_i), .is_inf_i(is_inf_i), .nv_i(nv_i), .dz_i(dz_i),
    .rm_i(rm_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .flags_o(flags_o)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int unsigned cyc;
    bit          lat;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0, n_pass = 0, cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
  endtask

  // Output monitor: compares the head of the scoreboard every cycle the
  // result is valid (so a stalled result is re-checked for stability).
  always @(negedge clk_i) begin
    if (reset_i === 1'b1 && valid_o === 1'b1) begin
      if (sb.size() == 0) check_eq("spurious_valid", 32'(valid_o), 32'd0);
      else begin
        check_eq({sb[0].tag, "_res"}, result_o, sb[0].res);
        check_eq({sb[0].tag, "_flags"}, 32'(flags_o), 32'(sb[0].flg));
        if (ready_i) begin
          if (sb[0].lat) check_eq({sb[0].tag, "_lat"}, cyc - sb[0].cyc, 32'd2);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit sg, input int e, input logic [26:0] sv, input bit st,
                       input logic [2:0] rm, input bit nan, input bit inf, input bit nv, input bit dz);
    sign_i = sg; exp_i = 10'(e); sig_i = sv; sticky_i = st; rm_i = rm;
    is_nan_i = nan; is_inf_i = inf; nv_i = nv; dz_i = dz; valid_i = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input string tag, input bit sg, input int e, input logic [26:0] sv,
                      input bit st, input logic [2:0] rm, input bit nan, input bit inf,
                      input bit nv, input bit dz, input logic [31:0] res, input logic [4:0] flg,
                      input bit lat);
    exp_t        x;
    int unsigned waitc = 0;
    drive(sg, e, sv, st, rm, nan, inf, nv, dz);
    x.res = res; x.flg = flg; x.lat = lat; x.tag = tag;
    forever begin
      @(negedge clk_i);
      if (ready_o) begin
        x.cyc = cyc;
        sb.push_back(x);
        @(posedge clk_i); #2;
        break;
      end
      @(posedge clk_i); #2;
      waitc++;
      if (waitc > 20) begin
        check_eq({tag, "_accept_timeout"}, 32'(ready_o), 32'd1);
        break;
      end
    end
  endtask

  task automatic drain();
    valid_i = 1'b0;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk_i);
    #2;
    check_eq("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    drive(0, 0, '0, 0, RM_RNE, 0, 0, 0, 0);
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    check_eq("rst_ready", 32'(ready_o), 32'd1);
    reset_i = 1'b1;
    @(posedge clk_i); #2;
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_result", result_o, 32'd0);
    check_eq("rst_flags", 32'(flags_o), 32'd0);

    send("one",         0, 127, 27'h2000000, 0, RM_RNE, 0, 0, 0, 0, 32'h3F80_0000, 5'd0, 1);
    send("carry",       0, 127, 27'h3FFFFFF, 0, RM_RNE, 0, 0, 0, 0, 32'h4000_0000, NX,   1);
    send("tie_rne",     0, 127, 27'h2000002, 0, RM_RNE, 0, 0, 0, 0, 32'h3F80_0000, NX,   1);
    send("tie_rup",     0, 127, 27'h2000002, 0, RM_RUP, 0, 0, 0, 0, 32'h3F80_0001, NX,   1);
    send("tie_rmm",     0, 127, 27'h2000002, 0, RM_RMM, 0, 0, 0, 0, 32'h3F80_0001, NX,   1);
    send("odd_rsvd",    0, 127, 27'h2000006, 0, 3'b111, 0, 0, 0, 0, 32'h3F80_0002, NX,   1);
    send("rdn_neg",     1, 127, 27'h2000001, 0, RM_RDN, 0, 0, 0, 0, 32'hBF80_0001, NX,   1);
    send("rdn_pos",     0, 127, 27'h2000001, 0, RM_RDN, 0, 0, 0, 0, 32'h3F80_0000, NX,   1);
    send("rsh_rne",     0, 127, 27'h4000001, 0, RM_RNE, 0, 0, 0, 0, 32'h4000_0000, NX,   1);
    send("rsh_rup",     0, 127, 27'h4000001, 0, RM_RUP, 0, 0, 0, 0, 32'h4000_0001, NX,   1);
    send("lsh",         0, 150, 27'h0000004, 0, RM_RNE, 0, 0, 0, 0, 32'h3F80_0000, 5'd0, 1);
    send("sticky_rup",  0, 127, 27'h2000000, 1, RM_RUP, 0, 0, 0, 0, 32'h3F80_0001, NX,   1);
    send("ovf_rne",     0, 300, 27'h2000000, 0, RM_RNE, 0, 0, 0, 0, 32'h7F80_0000, OF|NX, 1);
    send("ovf_rtz",     0, 300, 27'h2000000, 0, RM_RTZ, 0, 0, 0, 0, 32'h7F7F_FFFF, OF|NX, 1);
    send("ovf_rup_neg", 1, 300, 27'h2000000, 0, RM_RUP, 0, 0, 0, 0, 32'hFF7F_FFFF, OF|NX, 1);
    send("ovf_rdn_neg", 1, 300, 27'h2000000, 0, RM_RDN, 0, 0, 0, 0, 32'hFF80_0000, OF|NX, 1);
    send("ovf_round",   0, 254, 27'h3FFFFFF, 0, RM_RNE, 0, 0, 0, 0, 32'h7F80_0000, OF|NX, 1);
    send("maxfin_rtz",  0, 254, 27'h3FFFFFF, 0, RM_RTZ, 0, 0, 0, 0, 32'h7F7F_FFFF, NX,   1);
    send("nan",         0, 127, 27'h2000000, 0, RM_RNE, 1, 1, 1, 0, 32'h7FC0_0000, NV,   1);
    send("inf",         1, 127, 27'h2000000, 0, RM_RNE, 0, 1, 0, 1, 32'hFF80_0000, DZ,   1);
    send("zero",        1, 127, 27'h0000000, 0, RM_RNE, 0, 0, 0, 0, 32'h8000_0000, 5'd0, 1);
    send("pass_nvdz",   0, 127, 27'h2000000, 0, RM_RNE, 0, 0, 1, 1, 32'h3F80_0000, NV|DZ, 1);
`ifdef FPU_ENC_SUBNORMAL_EN
    send("tiny_exact",  0, -2,  27'h2000000, 0, RM_RNE, 0, 0, 0, 0, 32'h0010_0000, 5'd0,  1);
    send("tiny_carry",  0, 0,   27'h3FFFFFF, 0, RM_RNE, 0, 0, 0, 0, 32'h0080_0000, UF|NX, 1);
    send("tiny_sat",    0, -40, 27'h2000000, 0, RM_RUP, 0, 0, 0, 0, 32'h0000_0001, UF|NX, 1);
`else
    send("tiny_exact",  0, -2,  27'h2000000, 0, RM_RNE, 0, 0, 0, 0, 32'h0000_0000, UF|NX, 1);
    send("tiny_carry",  1, 0,   27'h3FFFFFF, 0, RM_RNE, 0, 0, 0, 0, 32'h8000_0000, UF|NX, 1);
    send("tiny_sat",    0, -40, 27'h2000000, 0, RM_RUP, 0, 0, 0, 0, 32'h0000_0000, UF|NX, 1);
`endif
    drain();

    // Backpressure: two operands fill the pipe, the third must wait.
    @(posedge clk_i); #2;
    ready_i = 1'b0;
    send("bp_a", 0, 127, 27'h2000000, 0, RM_RNE, 0, 0, 0, 0, 32'h3F80_0000, 5'd0, 0);
    send("bp_b", 0, 127, 27'h3FFFFFF, 0, RM_RNE, 0, 0, 0, 0, 32'h4000_0000, NX,   0);
    drive(0, 127, 27'h2000002, 0, RM_RUP, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("bp_ready", 32'(ready_o), 32'd0);
    end
    @(posedge clk_i); #2;
    ready_i = 1'b1;
    send("bp_c", 0, 127, 27'h2000002, 0, RM_RUP, 0, 0, 0, 0, 32'h3F80_0001, NX, 0);
    drain();

    // Reset while two operands are in flight.
    @(posedge clk_i); #2;
    send("rst_a", 0, 127, 27'h2000000, 0, RM_RNE, 0, 0, 0, 0, 32'h3F80_0000, 5'd0, 1);
    send("rst_b", 0, 127, 27'h3FFFFFF, 0, RM_RNE, 0, 0, 0, 0, 32'h4000_0000, NX,   1);
    reset_i = 1'b0;
    valid_i = 1'b0;
    sb.delete();
    @(posedge clk_i); #1;
    check_eq("midrst_valid", 32'(valid_o), 32'd0);
    check_eq("midrst_result", result_o, 32'd0);
    check_eq("midrst_ready", 32'(ready_o), 32'd1);
    #1;
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #2;
    check_eq("postrst_no_ghost", 32'(valid_o), 32'd0);
    send("post_rst", 1, 128, 27'h2000000, 0, RM_RNE, 0, 0, 0, 0, 32'hC000_0000, 5'd0, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
